// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and default widths, also used by the sequencer and decode.
package fetch_pkg;

    localparam int unsigned DefAw      = 16;
    localparam int unsigned DefDw      = 32;
    localparam int unsigned DefResetPc = 0;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Fetch wait-cycle counter; present only when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the WAIT cycle whose increment would bring the count to TIMEOUT.
    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory over req/ack, loads the IR.
// Optional fetch timeout with sticky fault is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned AW       = DefAw,
    parameter int unsigned DW       = DefDw,
    parameter int unsigned RESET_PC = DefResetPc,
    parameter int unsigned PC_STEP  = 1,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          fetch_req_i,
    input  logic          load_pc_i,
    input  logic [AW-1:0] pc_target_i,
    output logic          mem_rd_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [DW-1:0] ir_o,
    output logic          ir_valid_o,
    output logic [AW-1:0] pc_o,
    output logic          busy_o,
    output logic          fault_o
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("fetch_unit: TIMEOUT must be at least 1");
    end

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          busy_q, busy_d;
    logic          pend_q, pend_d;
    logic [AW-1:0] pend_pc_q, pend_pc_d;
    logic          expired;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        busy_d     = busy_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        unique case (state_q)
            StIdle: begin
                // Stray acks in IDLE fall through untouched.
                if (fetch_req_i) begin
                    mem_addr_d = load_pc_i ? pc_target_i : pc_q;
                    mem_rd_d   = 1'b1;
                    busy_d     = 1'b1;
                    pend_d     = 1'b0;
                    state_d    = StWait;
                end
                if (load_pc_i) begin
                    pc_d = pc_target_i;
                end
            end
            StWait: begin
                if (mem_ack_i) begin
                    ir_d       = mem_rdata_i;
                    ir_valid_d = 1'b1;
                    mem_rd_d   = 1'b0;
                    busy_d     = 1'b0;
                    pend_d     = 1'b0;
                    state_d    = StIdle;
                    if (load_pc_i) begin
                        pc_d = pc_target_i;
                    end else if (pend_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_q + AW'(PC_STEP);
                    end
                end else if (expired) begin
                    mem_rd_d = 1'b0;
                    busy_d   = 1'b0;
                    pend_d   = 1'b0;
                    state_d  = StIdle;
                end else if (load_pc_i) begin
                    pend_d    = 1'b1;
                    pend_pc_d = pc_target_i;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            pc_q       <= AW'(RESET_PC);
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= AW'(RESET_PC);
            busy_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic fault_q;

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   ((state_q == StIdle) && fetch_req_i),
        .enable_i  ((state_q == StWait) && !mem_ack_i),
        .expired_o (expired)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fault_q <= 1'b0;
        end else if ((state_q == StWait) && !mem_ack_i && expired) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_o = fault_q;
`else
    assign expired = 1'b0;
    assign fault_o = 1'b0;
`endif

    assign mem_rd_o   = mem_rd_q;
    assign mem_addr_o = mem_addr_q;
    assign ir_o       = ir_q;
    assign ir_valid_o = ir_valid_q;
    assign pc_o       = pc_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; timeout cases run when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic        load_pc;
    logic [15:0] pc_target;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic [15:0] pc;
    logic        busy;
    logic        fault;

    int n_cmp;
    int n_err;

    fetch_unit u_dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .fetch_req_i (fetch_req),
        .load_pc_i   (load_pc),
        .pc_target_i (pc_target),
        .mem_rd_o    (mem_rd),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .ir_o        (ir),
        .ir_valid_o  (ir_valid),
        .pc_o        (pc),
        .busy_o      (busy),
        .fault_o     (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // mode: 0 none, 1 load_pc with fetch_req, 2 load_pc in first WAIT cycle,
    // 3 load_pc tgt in WAIT cycle 1 then tgt+0x100 in cycle 2 (overwrite).
    task automatic fetch(input int wait_n, input logic [31:0] data, input logic [15:0] exp_addr,
                         input logic [15:0] exp_pc, input int mode, input logic [15:0] tgt);
        logic [31:0] ir_before;
        ir_before = ir;
        fetch_req = 1'b1;
        if (mode == 1) begin
            load_pc   = 1'b1;
            pc_target = tgt;
        end
        tick();
        fetch_req = 1'b0;
        load_pc   = 1'b0;
        check("issue_mem_rd", {31'd0, mem_rd}, 32'd1);
        check("issue_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
        for (int i = 0; i < wait_n; i++) begin
            check("wait_busy", {31'd0, busy}, 32'd1);
            check("wait_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
            check("wait_ir", ir, ir_before);
            fetch_req = 1'b1;
            if ((mode == 2 || mode == 3) && i == 0) begin
                load_pc   = 1'b1;
                pc_target = tgt;
            end
            if (mode == 3 && i == 1) begin
                load_pc   = 1'b1;
                pc_target = tgt + 16'h0100;
            end
            tick();
            fetch_req = 1'b0;
            load_pc   = 1'b0;
        end
        check("pre_ack_mem_rd", {31'd0, mem_rd}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("done_ir", ir, data);
        check("done_ir_valid", {31'd0, ir_valid}, 32'd1);
        check("done_pc", {16'd0, pc}, {16'd0, exp_pc});
        check("done_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        fetch_req = 1'b0;
        load_pc   = 1'b0;
        pc_target = 16'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        do_reset();
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);

        // Zero-wait fetch: ir_valid must be a single pulse.
        fetch(0, 32'hDEADBEEF, 16'h0000, 16'h0001, 0, 16'h0);
        tick();
        check("single_pulse", {31'd0, ir_valid}, 32'd0);
        check("ir_hold", ir, 32'hDEADBEEF);

        // Three back-to-back fetches, 3-cycle ack delay, stray fetch_req during WAIT.
        do_reset();
        fetch(2, 32'h1111_0000, 16'h0000, 16'h0001, 0, 16'h0);
        fetch(2, 32'h2222_0001, 16'h0001, 16'h0002, 0, 16'h0);
        fetch(2, 32'h3333_0002, 16'h0002, 16'h0003, 0, 16'h0);

        // Branch mid-WAIT, then fetch from the branch target.
        fetch(2, 32'hA5A5_0003, 16'h0003, 16'h0100, 2, 16'h0100);
        fetch(1, 32'hB0B0_0100, 16'h0100, 16'h0101, 0, 16'h0);
        // Later load_pc in the same WAIT overwrites the pending target.
        fetch(3, 32'hC0C0_0101, 16'h0101, 16'h0300, 3, 16'h0200);
        // fetch_req and load_pc together in IDLE.
        fetch(1, 32'hD0D0_0040, 16'h0040, 16'h0041, 1, 16'h0040);

        // load_pc alone in IDLE, then wrap from all-ones.
        tick();
        load_pc   = 1'b1;
        pc_target = 16'hFFFF;
        tick();
        load_pc = 1'b0;
        check("idle_load_pc", {16'd0, pc}, 32'h0000_FFFF);
        check("idle_load_no_rd", {31'd0, mem_rd}, 32'd0);
        fetch(0, 32'hE0E0_FFFF, 16'hFFFF, 16'h0000, 0, 16'h0);

        // Stray ack in IDLE is ignored.
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check("stray_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("stray_ir", ir, 32'hE0E0_FFFF);
        check("stray_pc", {16'd0, pc}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int rd_cycles;
            int saw_valid;
            rd_cycles = 0;
            saw_valid = 0;
            fetch_req = 1'b1;
            tick();
            fetch_req = 1'b0;
            while (mem_rd && rd_cycles < 40) begin
                rd_cycles++;
                tick();
                if (ir_valid) saw_valid = 1;
            end
            check("to_wait_cycles", rd_cycles, 32'd15);
            check("to_fault", {31'd0, fault}, 32'd1);
            check("to_busy", {31'd0, busy}, 32'd0);
            check("to_pc", {16'd0, pc}, 32'd0);
            check("to_ir", ir, 32'hE0E0_FFFF);
            check("to_no_valid", saw_valid, 32'd0);
        end
        // Ack on the expiry cycle wins; fault stays sticky.
        fetch(14, 32'h7777_0000, 16'h0000, 16'h0001, 0, 16'h0);
        check("to_fault_sticky", {31'd0, fault}, 32'd1);
`else
        // Without the timeout, WAIT persists well beyond 15 cycles.
        fetch(20, 32'h7777_0000, 16'h0000, 16'h0001, 0, 16'h0);
        check("no_to_fault", {31'd0, fault}, 32'd0);
`endif

        // Reset in WAIT cycle 5 abandons the fetch; a late ack is ignored.
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_mem_rd", {31'd0, mem_rd}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("midrst_fault", {31'd0, fault}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_pc", {16'd0, pc}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        check("late_ack_valid", {31'd0, ir_valid}, 32'd0);
        check("late_ack_ir", ir, 32'd0);
        check("late_ack_pc", {16'd0, pc}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly downstream of the control sequencer's fetch phase and upstream of decode. On each fetch request it reads one instruction word from program memory over a request/acknowledge handshake and latches it into the instruction register. It owns the program counter: it increments the counter after every completed fetch and reloads it on branch requests from execute.

## Interface
- AW, 16: program-counter and memory-address width; word-addressed.
- DW, 32: instruction width.
- RESET_PC, 0: PC value after reset.
- PC_STEP, 1: increment applied after each completed fetch.
- TIMEOUT, 15: maximum wait cycles for `mem_ack`. Used only with FETCH_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- fetch_req  in  1  one-cycle pulse from the sequencer on entry to its fetch phase.
- load_pc  in  1  branch taken; load `pc_target`.
- pc_target  in  AW  branch destination.
- mem_rd  out  1  read request to program memory (registered).
- mem_addr  out  AW  read address (registered); stable while `mem_rd` is high.
- mem_ack  in  1  memory has valid `mem_rdata` this cycle.
- mem_rdata  in  DW  instruction word.
- ir  out  DW  instruction register; holds its value until the next completed fetch.
- ir_valid  out  1  one-cycle pulse when `ir` has just been loaded.
- pc  out  AW  current program counter.
- busy  out  1  high while a fetch is outstanding.
- fault  out  1  sticky fetch-timeout flag.

## Operation
- Two states: IDLE and WAIT.
- IDLE, `fetch_req` = 1:
  - `mem_addr` ← fetch address; `mem_rd` ← 1; `busy` ← 1; go to WAIT.
  - The fetch address is `pc`. If `load_pc` is also high, it is `pc_target`, and `pc` ← `pc_target` on the same edge.
- IDLE, `load_pc` only: `pc` ← `pc_target`.
- IDLE, `mem_ack` = 1: ignored. This covers stray or late acks.
- WAIT, `mem_ack` = 1:
  - `ir` ← `mem_rdata`; `ir_valid` ← 1 for one cycle.
  - `mem_rd` ← 0; `busy` ← 0; go to IDLE.
  - `pc` ← `pc_target` if `load_pc` was seen during this WAIT (latched pending flag) or is high this cycle. Otherwise `pc` ← `pc` + PC_STEP.
- WAIT, `fetch_req` = 1: ignored; no queuing.
- WAIT, `load_pc` = 1: latch `pc_target` into a pending register. Applied at completion; a later `load_pc` in the same WAIT overwrites it.
- Arithmetic: PC increments modulo 2^AW. All-ones + 1 wraps to 0 with no flag.
- Reset values: `pc` = RESET_PC, `ir` = 0, `mem_addr` = RESET_PC. `mem_rd`, `ir_valid`, `busy`, `fault` = 0. Pending branch cleared; state = IDLE.
- Reset mid-WAIT: the fetch is abandoned, `mem_rd` is low after that edge, and any subsequent `mem_ack` is ignored.

## Timing
- `fetch_req` sampled at edge N → `mem_rd`/`mem_addr` valid after edge N.
- `mem_ack` sampled at edge M (M ≥ N+1) → `ir`, `ir_valid`, the new `pc`, and `mem_rd` = 0 after edge M.
- Minimum fetch latency: 2 cycles from `fetch_req` to `ir_valid`, with zero-wait memory acknowledging in the first `mem_rd` cycle.
- `mem_addr` and `mem_rd` are held constant for the whole of WAIT.
- Back-to-back fetches:
  - `fetch_req` in the cycle `ir_valid` is high is accepted (state is IDLE again), using the updated `pc`.
  - Issue rate is one fetch per 2 cycles.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A wait counter clears on entry to WAIT and increments every WAIT cycle without `mem_ack`.
  - When it reaches TIMEOUT: `mem_rd` ← 0, `busy` ← 0, `fault` ← 1 (sticky until reset), return to IDLE. `pc` and `ir` are unchanged, no `ir_valid`, and the pending branch is discarded.
  - `mem_ack` in the expiry cycle wins: the fetch completes normally.
- FETCH_TIMEOUT_EN undefined: WAIT persists indefinitely; `fault` is tied to 0; no counter logic.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE, WAIT);
  - default AW/DW/RESET_PC constants, shared with the sequencer and decode.
- One sub-module, `fetch_watchdog`:
  - the timeout counter with clear/enable inputs and an `expired` output;
  - instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Reset, then `fetch_req` with memory acking one cycle later with 0xDEADBEEF:
  - `mem_addr` = 0;
  - `ir` = 0xDEADBEEF with a single `ir_valid` pulse;
  - `pc` = 1.
- Three back-to-back fetches with 3-cycle ack delay: addresses 0, 1, 2; `busy` high throughout each WAIT; extra `fetch_req` pulses during WAIT are ignored.
- `load_pc` to 0x0100 asserted mid-WAIT: after the ack, `pc` = 0x0100 (not +1); the next fetch address is 0x0100.
- `fetch_req` and `load_pc` (target 0x0040) together in IDLE: `mem_addr` = 0x0040; after the ack, `pc` = 0x0041.
- PC wrap: `load_pc` to 0xFFFF, then a fetch: `pc` becomes 0x0000.
- FETCH_TIMEOUT_EN, TIMEOUT = 15, no ack: `mem_rd` drops after 15 WAIT cycles; `fault` = 1 until reset; `pc` unchanged. Repeat with reset asserted in WAIT cycle 5: `mem_rd` = 0 and `fault` = 0 after that edge.
